seg_scan_driver: RTL



---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 6-digit 7-segment scan driver: digit count,
// idle levels, active-low hex segment table and scan FSM encoding.
package seg_pkg;

  localparam int DIGITS = 6;

  localparam logic [7:0]        SEG_OFF = 8'hFF;
  localparam logic [DIGITS-1:0] SEL_OFF = 6'h3F;

  localparam logic S_BLANK = 1'b0;
  localparam logic S_DRIVE = 1'b1;

  typedef logic [DIGITS-1:0][3:0] digits_t;

  // {dp,g,f,e,d,c,b,a} active low, dp always off; entry [15] listed first
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex code to active-low 7-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit common-anode scan driver with per-slot blanking and frame-coherent
// shadow latching. Optional SEG_LEADING_ZERO_BLANK_EN darkens leading zeros.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int TIME_SCAN = 50_000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] din,
  input  logic [5:0]  din_mask,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int            CW         = $clog2(TIME_SCAN);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIME_SCAN - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit            NO_BLANK   = (BLANK_CYC == 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          state_q, state_d;
  digits_t       shadow_din_q, shadow_din_d;
  logic [5:0]    shadow_mask_q, shadow_mask_d;
  logic          pend_q, pend_d;
  logic [5:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;

  logic          tc, load;
  logic [5:0]    en_mask;
  logic [3:0]    cur_digit;
  logic [7:0]    dec_seg;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [5:0] lz;
  logic       upper_zero;

  // lz[i]: digit i and everything to its left are zero; digit 0 always shows
  always_comb begin
    lz         = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (shadow_din_q[i] == 4'd0);
      lz[i]      = upper_zero;
    end
    en_mask = shadow_mask_q & ~lz;
  end
`else
  assign en_mask = shadow_mask_q;
`endif

  assign cur_digit = shadow_din_q[idx_q];

  seg_hex_decode u_dec (
    .code_i (cur_digit),
    .seg_o  (dec_seg)
  );

  always_comb begin
    tc     = (cnt_q == CNT_LAST);
    cnt_d  = tc ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tc) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    // first clock after reset, or the clock closing digit 5's slot
    load          = pend_q | (tc & (idx_q == 3'd5));
    shadow_din_d  = load ? din      : shadow_din_q;
    shadow_mask_d = load ? din_mask : shadow_mask_q;
    pend_d        = 1'b0;

    state_d = state_q;
    if (NO_BLANK)                                      state_d = S_DRIVE;
    else if (tc)                                       state_d = S_BLANK;
    else if (state_q == S_BLANK && cnt_q == BLANK_LAST) state_d = S_DRIVE;

    // outputs follow the current counter/state one clock later
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    if (state_q == S_DRIVE && en_mask[idx_q]) begin
      sel_d[idx_q] = 1'b0;
      seg_d        = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      state_q       <= S_BLANK;
      shadow_din_q  <= '0;
      shadow_mask_q <= '0;
      pend_q        <= 1'b1;
      sel_q         <= SEL_OFF;
      seg_q         <= SEG_OFF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      shadow_din_q  <= shadow_din_d;
      shadow_mask_q <= shadow_mask_d;
      pend_q        <= pend_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule
